// File: rtl/ahbs_flash_rd_ctrl.sv
// ahbs_flash_rd_ctrl: AHB-Lite read-only slave in front of a synchronous embedded flash macro.
//
// Single, non-sequential transfers only. A valid read issues a one-cycle flash_req_o, then holds
// hreadyout_o low until the flash data is valid (WAIT_CYCLES after the request). Writes, sizes
// above a word and misaligned accesses get a two-cycle ERROR response and never reach the flash.
//
// Optional feature (macro FLASH_RDBUF_EN): a one-entry read buffer {valid, word address, data}
// that is filled on every read-miss completion and serves repeated word reads with zero waits.
//
// Ports:
//   hclk_i, hresetn_i        clock, asynchronous active-low reset
//   hsel_i .. hready_i       AHB-Lite address-phase inputs (hwdata_i unused)
//   hrdata_o, hreadyout_o,   AHB-Lite data-phase outputs
//   hresp_o
//   flash_req_o              one-cycle read strobe to the flash macro
//   flash_addr_o             flash word address, held until the next request
//   flash_rdata_i            flash read data
//   rdbuf_flush_i            invalidates the read buffer (unused without FLASH_RDBUF_EN)
module ahbs_flash_rd_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              hclk_i,
  input  logic              hresetn_i,
  input  logic              hsel_i,
  input  logic [31:0]       haddr_i,
  input  logic [1:0]        htrans_i,
  input  logic              hwrite_i,
  input  logic [2:0]        hsize_i,
  input  logic [31:0]       hwdata_i,
  input  logic              hready_i,
  output logic [31:0]       hrdata_o,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic              flash_req_o,
  output logic [ADDR_W-3:0] flash_addr_o,
  input  logic [31:0]       flash_rdata_i,
  input  logic              rdbuf_flush_i
);

  localparam int unsigned WAddrW   = ADDR_W - 2;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StRd, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic              flash_req_q, flash_req_d;
  logic [WAddrW-1:0] flash_addr_q, flash_addr_d;
  logic              hit_q, hit_d;

  logic              rd_done;
  logic              accept;
  logic              addr_phase;
  logic              aligned;
  logic              rd_ok;
  logic [WAddrW-1:0] req_waddr;
  logic              buf_hit;
  logic [31:0]       buf_rdata;

  // Completion cycle of a flash read: the counter has run out.
  assign rd_done    = (state_q == StRd) && (cnt_q == 4'd0);
  // A new address phase may only be taken when the current data phase is in its last cycle.
  assign accept     = (state_q == StIdle) || rd_done || (state_q == StErr2);
  assign addr_phase = accept && hsel_i && hready_i && htrans_i[1];
  assign req_waddr  = haddr_i[ADDR_W-1:2];

  always_comb begin
    aligned = 1'b0;
    unique case (hsize_i)
      3'b000:  aligned = 1'b1;
      3'b001:  aligned = ~haddr_i[0];
      3'b010:  aligned = (haddr_i[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign rd_ok = ~hwrite_i && aligned;

`ifdef FLASH_RDBUF_EN
  logic              buf_valid_q;
  logic [WAddrW-1:0] buf_addr_q;
  logic [31:0]       buf_data_q;
  logic              eff_valid;
  logic [WAddrW-1:0] eff_addr;

  // An address phase in a miss-completion cycle sees the entry that is being filled this cycle.
  assign eff_valid = rd_done || buf_valid_q;
  assign eff_addr  = rd_done ? flash_addr_q : buf_addr_q;
  assign buf_hit   = eff_valid && (eff_addr == req_waddr) && ~rdbuf_flush_i;
  assign buf_rdata = buf_data_q;

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      if (rdbuf_flush_i) begin
        buf_valid_q <= 1'b0;
      end else if (rd_done) begin
        buf_valid_q <= 1'b1;
      end
      if (rd_done) begin
        buf_addr_q <= flash_addr_q;
        buf_data_q <= flash_rdata_i;
      end
    end
  end

  logic unused_sigs;
  assign unused_sigs = ^{hwdata_i, haddr_i[31:ADDR_W], htrans_i[0]};
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = '0;

  logic unused_sigs;
  assign unused_sigs = ^{hwdata_i, haddr_i[31:ADDR_W], htrans_i[0], rdbuf_flush_i};
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flash_req_d  = 1'b0;
    flash_addr_d = flash_addr_q;
    hit_d        = 1'b0;

    unique case (state_q)
      StIdle: ;
      StRd: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StIdle;
        end
      end
      StErr1: state_d = StErr2;
      StErr2: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (addr_phase) begin
      if (!rd_ok) begin
        state_d = StErr1;
      end else if (buf_hit) begin
        state_d = StIdle;
        hit_d   = 1'b1;
      end else begin
        state_d      = StRd;
        cnt_d        = WaitLoad;
        flash_req_d  = 1'b1;
        flash_addr_d = req_waddr;
      end
    end

    // Registered data-phase handshake, decoded from the next state.
    hresp_d     = (state_d == StErr1) || (state_d == StErr2);
    hreadyout_d = !((state_d == StErr1) || ((state_d == StRd) && (cnt_d != 4'd0)));
  end

  always_ff @(posedge hclk_i or negedge hresetn_i) begin
    if (!hresetn_i) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      hreadyout_q  <= 1'b1;
      hresp_q      <= 1'b0;
      flash_req_q  <= 1'b0;
      flash_addr_q <= '0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hreadyout_q  <= hreadyout_d;
      hresp_q      <= hresp_d;
      flash_req_q  <= flash_req_d;
      flash_addr_q <= flash_addr_d;
      hit_q        <= hit_d;
    end
  end

  assign hreadyout_o  = hreadyout_q;
  assign hresp_o      = hresp_q;
  assign flash_req_o  = flash_req_q;
  assign flash_addr_o = flash_addr_q;
  assign hrdata_o     = rd_done ? flash_rdata_i : (hit_q ? buf_rdata : 32'd0);

`ifndef SYNTHESIS
  wait_cycles_legal_a: assert property (@(posedge hclk_i)
    (WAIT_CYCLES >= 1) && (WAIT_CYCLES <= 15));
`endif

endmodule
